// File: rtl/inst_queue_pkg.sv
// Shared constants and helper types for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int unsigned ISA_WIDTH  = 32;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam int unsigned IFQ_DEPTH  = 4;
  localparam int unsigned PERF_WIDTH = 16;

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_PUSH,
    Q_POP,
    Q_BOTH
  } q_op_e;

  function automatic q_op_e classify_op(input logic push, input logic pop);
    unique case ({push, pop})
      2'b10:   classify_op = Q_PUSH;
      2'b01:   classify_op = Q_POP;
      2'b11:   classify_op = Q_BOTH;
      default: classify_op = Q_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ifq_sat_counter.sv
// 16-bit event counter that sticks at all-ones; cleared only by reset.
module ifq_sat_counter
  import inst_queue_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inc,
  output logic [PERF_WIDTH-1:0] value
);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode; flush drops all entries.
// Perf counters are built only when IFQ_PERF_COUNT_EN is defined.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned WIDTH = ISA_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_inst,
  input  logic [WIDTH-1:0]         in_link,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_inst,
  output logic [WIDTH-1:0]         out_link,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [PERF_WIDTH-1:0]    stall_cycles,
  output logic [PERF_WIDTH-1:0]    flush_events
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [2*WIDTH-1:0] head;

  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
  logic [CNT_W-1:0] count_q, count_next;
  logic             push, pop;
  q_op_e            op;

  // Ready and valid come from registered occupancy only, so a pop on a full
  // queue never opens a slot in the same cycle.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    op         = classify_op(push, pop);
    rd_next    = rd_ptr;
    wr_next    = wr_ptr;
    count_next = count_q;
    if (flush) begin
      rd_next    = '0;
      wr_next    = '0;
      count_next = '0;
    end else begin
      unique case (op)
        Q_PUSH: begin
          wr_next    = wr_ptr + 1'b1;
          count_next = count_q + 1'b1;
        end
        Q_POP: begin
          rd_next    = rd_ptr + 1'b1;
          count_next = count_q - 1'b1;
        end
        Q_BOTH: begin
          wr_next = wr_ptr + 1'b1;
          rd_next = rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_next;
      wr_ptr  <= wr_next;
      count_q <= count_next;
    end
  end

  // Storage is deliberately left uninitialised; outputs are masked instead.
  always_ff @(posedge clock) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= {in_link, in_inst};
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    out_inst = WIDTH'(NOP_INST);
    out_link = '0;
    if (out_valid) begin
      out_inst = head[WIDTH-1:0];
      out_link = head[2*WIDTH-1:WIDTH];
    end
  end

`ifdef IFQ_PERF_COUNT_EN
  ifq_sat_counter u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (in_valid & ~in_ready),
    .value (stall_cycles)
  );

  ifq_sat_counter u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush),
    .value (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus pushes expected entries, a negedge
// monitor pops and compares whenever the decoder side handshakes.
module tb_inst_queue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_link;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_link;
  logic        flush;
  logic [2:0]  count;
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;

`ifdef IFQ_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit mon_en    = 1'b0;
  logic [63:0] exp_q [$];

  inst_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_link      (in_link),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_link     (out_link),
    .flush        (flush),
    .count        (count),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] perf_exp(input int n);
    return PERF ? 16'(n) : 16'h0;
  endfunction

  // Monitor: the handshake sampled here is the one the next posedge commits.
  always @(negedge clock) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_pop: got inst %h link %h expected no output", out_inst, out_link);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("pop_inst", out_inst, e[31:0]);
          check("pop_link", out_link, e[63:32]);
        end
      end
      if (!out_valid) begin
        check("nop_inst", out_inst, 32'h0);
        check("nop_link", out_link, 32'h0);
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_inst"}, out_inst, 32'h0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hDEAD_0001; in_link = 32'h10;
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0;
    check_idle("reset");
    check("reset_out_link", out_link, 32'h0);
    check("reset_stall", 32'(stall_cycles), 32'h0);
    check("reset_flushev", 32'(flush_events), 32'h0);
    mon_en = 1'b1;

    // Single push, no bypass: visible the cycle after the push edge.
    in_valid = 1'b1; in_inst = 32'h2008_0005; in_link = 32'h4;
    check("nobypass_valid", 32'(out_valid), 32'd0);
    exp_q.push_back({32'h4, 32'h2008_0005});
    tick();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_inst", out_inst, 32'h2008_0005);
    check("single_link", out_link, 32'h4);
    check("single_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    check_idle("single_drain");
    tick();
    check_idle("empty_pop");
    out_ready = 1'b0;

    // Fill to DEPTH, then stall and a full-plus-pop attempt.
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_inst = 32'hA000_0000 + 32'(i); in_link = 32'h100 + 32'(4 * i);
      exp_q.push_back({in_link, in_inst});
      tick();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_inst = 32'hB000_0005; in_link = 32'h200;
    tick();
    check("stall_count", 32'(count), 32'd4);
    check("stall_cycles1", 32'(stall_cycles), 32'(perf_exp(1)));
    out_ready = 1'b1;
    tick();
    check("fullpop_count", 32'(count), 32'd3);
    check("stall_cycles2", 32'(stall_cycles), 32'(perf_exp(2)));
    out_ready = 1'b0;
    exp_q.push_back({32'h200, 32'hB000_0005});
    tick();
    check("refill_count", 32'(count), 32'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check_idle("drain4");
    out_ready = 1'b0;

    // Streaming push+pop; occupancy stays at 1 and pointers wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_inst = 32'hC000_0000 + 32'(i); in_link = 32'h300 + 32'(4 * i);
      exp_q.push_back({in_link, in_inst});
      tick();
      check("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check_idle("stream_end");
    out_ready = 1'b0;

    // Flush with simultaneous push and pop on a 3-entry queue.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = 32'hD000_0000 + 32'(i); in_link = 32'h400 + 32'(4 * i);
      exp_q.push_back({in_link, in_inst});
      tick();
    end
    check("preflush_count", 32'(count), 32'd3);
    in_inst = 32'hD000_0003; in_link = 32'h40C; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    check_idle("flush");
    check("flush_events", 32'(flush_events), 32'(perf_exp(1)));
    check("flush_keeps_stall", 32'(stall_cycles), 32'(perf_exp(2)));
    in_valid = 1'b1; in_inst = 32'hE000_0000; in_link = 32'h500;
    exp_q.push_back({in_link, in_inst});
    tick();
    in_valid = 1'b0;
    check("postflush_inst", out_inst, 32'hE000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset with a full queue and in_valid held high.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = 32'hF000_0000 + 32'(i); in_link = 32'h600 + 32'(4 * i);
      tick();
    end
    check("prereset_count", 32'(count), 32'd4);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check_idle("midreset");
    check("midreset_link", out_link, 32'h0);
    check("midreset_stall", 32'(stall_cycles), 32'h0);
    check("midreset_flushev", 32'(flush_events), 32'h0);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check_idle("postreset");

    // Twenty stall cycles on a full queue.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = 32'h9000_0000 + 32'(i); in_link = 32'h700 + 32'(4 * i);
      exp_q.push_back({in_link, in_inst});
      tick();
    end
    in_inst = 32'h9000_00FF;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("stall20", 32'(stall_cycles), 32'(perf_exp(k)));
      check("stall20_flushev", 32'(flush_events), 32'h0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check_idle("final");
    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
